serial_subtractor: RTL



---
 rtl/serial_subtractor.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = a - b - bin.
// One full-subtractor cell plus a borrow flop processes one bit per clock,
// LSB first, behind a start/done handshake.
//
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow
// output ovf. Without the macro the port and its logic do not exist.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   start  - request, sampled only while ready=1
//   a, b   - minuend / subtrahend, captured on the accepting edge
//   bin    - borrow-in, captured on the accepting edge
//   ready  - can accept start (IDLE or DONE)
//   busy   - subtraction in progress (RUN)
//   done   - one-cycle pulse, result valid
//   diff   - result, held from done until the next completion
//   bout   - final borrow-out, held with diff
//   ovf    - signed overflow (SERIAL_SUB_OVF_EN only)
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter must hold 0..WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              br_q, br_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              bout_q, bout_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  logic             d_bit;
  logic             br_nxt;
  logic             last;
  logic [WIDTH-1:0] res_shift;

  // Full-subtractor cell on the current LSBs.
  assign d_bit     = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
  assign br_nxt    = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
  assign last      = (cnt_q == CW'(WIDTH - 1));
  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at [0].
  assign res_shift = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        res_d  = res_shift;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = br_nxt;
        if (last) begin
          state_d = S_DONE;
          diff_d  = res_shift;
          bout_d  = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
          // On the last edge the shift registers' LSBs are the operand MSBs.
          ovf_d   = (a_sh_q[0] != b_sh_q[0]) && (d_bit != a_sh_q[0]);
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d != S_RUN);
    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign diff  = diff_q;
  assign bout  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule
